scan_chain_array: RTL and testbench

Parametrised successor to the single mock scan chain. It holds NUM_CHAINS parallel configuration chains of CHAIN_LEN bits each, shifted together on the PMU test clock. A bit counter ends each transfer automatically. A shadow configuration register is committed only when a load completes in full, and a nondestructive readback mode shifts the committed configuration back out. It sits between the PMU/JTAG shift logic and the fabric configuration bits; cfg_out drives the fabric.

---
 rtl/scan_chain_pkg.sv | 21 ++
 rtl/scan_chain_lane.sv | 42 ++++
 rtl/scan_chain_array.sv | 104 ++++++++++
 tb/tb_scan_chain_array.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_chain_pkg.sv
// Shared types for the parallel scan chain array:
// FSM states, transfer modes and lane strobes.
package scan_chain_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    localparam logic MODE_LOAD     = 1'b0;
    localparam logic MODE_READBACK = 1'b1;

    typedef struct packed {
        logic shift;
        logic capture;
        logic commit;
    } lane_ctl_t;

endpackage

// File: rtl/scan_chain_lane.sv
// One configuration lane: serial chain register
// plus the shadow copy that drives the fabric.
module scan_chain_lane
    import scan_chain_pkg::*;
#(
    parameter int LEN = 10
) (
    input  logic           clk,
    input  logic           clear,
    input  lane_ctl_t      ctl,
    input  logic           din,
    output logic           dout,
    output logic [LEN-1:0] cfg
);

    logic [LEN-1:0] chain;
    logic [LEN-1:0] shadow;

    // chain: reload from shadow on capture, else shift toward bit 0
    always_ff @(posedge clk) begin
        if (clear) begin
            chain <= '0;
        end else if (ctl.capture) begin
            chain <= shadow;
        end else if (ctl.shift) begin
            chain <= {din, chain[LEN-1:1]};
        end
    end

    // shadow: take the chain only when a full load commits
    always_ff @(posedge clk) begin
        if (clear) begin
            shadow <= '0;
        end else if (ctl.commit) begin
            shadow <= chain;
        end
    end

    assign dout = chain[0];
    assign cfg  = shadow;

endmodule

// File: rtl/scan_chain_array.sv
// NUM_CHAINS parallel config chains with a shared
// bit counter, commit-on-complete shadow and readback.
module scan_chain_array
    import scan_chain_pkg::*;
#(
    parameter int CHAIN_LEN  = 10,
    parameter int NUM_CHAINS = 1
) (
    input  logic                            pmu_tck_in,
    input  logic                            clear,
    input  logic                            sc_en,
    input  logic                            sc_mode,
    input  logic [NUM_CHAINS-1:0]           sc_data_in,
    output logic [NUM_CHAINS-1:0]           sc_data_out,
    output logic                            sc_busy,
    output logic                            sc_done,
    output logic [NUM_CHAINS*CHAIN_LEN-1:0] cfg_out,
    output logic                            cfg_valid
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    state_t        state;
    logic          mode;
    logic          armed;
    logic [CW-1:0] cnt;
    lane_ctl_t     ctl;

    // lane strobes decoded from the current state
    always_comb begin
        ctl = '0;
        unique case (1'b1)
            state == CAPTURE: ctl.capture = 1'b1;
            state == SHIFT:   ctl.shift   = sc_en;
            state == UPDATE:  ctl.commit  = (mode == MODE_LOAD);
            default:          ctl         = '0;
        endcase
    end

    // transfer FSM, bit counter and start re-arm
    always_ff @(posedge pmu_tck_in) begin
        if (clear) begin
            state <= IDLE;
            mode  <= MODE_LOAD;
            armed <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (armed && sc_en) begin
                        armed <= 1'b0;
                        mode  <= sc_mode;
                        state <= (sc_mode == MODE_READBACK)
                               ? CAPTURE : SHIFT;
                    end else if (!sc_en) begin
                        armed <= 1'b1;
                    end
                end
                CAPTURE: state <= SHIFT;
                SHIFT: begin
                    if (sc_en) begin
                        if (cnt == LAST) begin
                            state <= UPDATE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // sticky flag: a full load has been committed since clear
    always_ff @(posedge pmu_tck_in) begin
        if (clear) begin
            cfg_valid <= 1'b0;
        end else if (ctl.commit) begin
            cfg_valid <= 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_lane
        scan_chain_lane #(
            .LEN (CHAIN_LEN)
        ) u_lane (
            .clk  (pmu_tck_in),
            .clear(clear),
            .ctl  (ctl),
            .din  (sc_data_in[c]),
            .dout (sc_data_out[c]),
            .cfg  (cfg_out[c*CHAIN_LEN +: CHAIN_LEN])
        );
    end

    assign sc_busy = (state != IDLE);
    assign sc_done = (state == UPDATE);

endmodule

// File: tb/tb_scan_chain_array.sv
// Bench for scan_chain_array: table vectors, clear
// corner cases and random transfers against a shadow model.
module tb_scan_chain_array;

    localparam int LEN = 10;
    localparam int NC  = 2;
    localparam int W   = LEN * NC;

    logic          clk;
    logic          clear;
    logic          sc_en;
    logic          sc_mode;
    logic [NC-1:0] sc_data_in;
    logic [NC-1:0] sc_data_out;
    logic          sc_busy;
    logic          sc_done;
    logic [W-1:0]  cfg_out;
    logic          cfg_valid;

    int checks = 0;
    int errors = 0;

    // reference model: what the fabric should see
    logic [W-1:0] mshadow;
    logic         mvalid;

    scan_chain_array #(
        .CHAIN_LEN (LEN),
        .NUM_CHAINS(NC)
    ) dut (
        .pmu_tck_in (clk),
        .clear      (clear),
        .sc_en      (sc_en),
        .sc_mode    (sc_mode),
        .sc_data_in (sc_data_in),
        .sc_data_out(sc_data_out),
        .sc_busy    (sc_busy),
        .sc_done    (sc_done),
        .cfg_out    (cfg_out),
        .cfg_valid  (cfg_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         m;
        logic [W-1:0] d;
        int           pat;
        int           plen;
        logic         hold;
        int           exp_lat;
        logic [W-1:0] exp_cfg;
        logic         exp_valid;
        logic [W-1:0] exp_rb;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // one complete transfer; d bit c*LEN+k goes in on shift k
    task automatic xfer(input string tag,
                        input logic m,
                        input logic [W-1:0] d,
                        input int pat,
                        input int plen,
                        input logic hold,
                        output int lat,
                        output logic [W-1:0] rb);
        int n;
        rb  = '0;
        lat = 0;
        sc_en = 1'b0;
        step();
        sc_mode = m;
        sc_en   = 1'b1;
        step();
        sc_mode = ~m;
        chk({tag, " busy@start"}, 32'(sc_busy), 32'd1);
        if (m) begin
            step();
            lat++;
        end
        for (int k = 0; k < LEN; k++) begin
            for (int c = 0; c < NC; c++) begin
                sc_data_in[c] = d[c*LEN+k];
                rb[c*LEN+k]   = sc_data_out[c];
            end
            if (sc_done !== 1'b0) begin
                chk({tag, " early done"}, 32'(sc_done), 32'd0);
            end
            step();
            lat++;
            if (k == pat) begin
                for (int p = 0; p < plen; p++) begin
                    sc_en      = 1'b0;
                    sc_data_in = NC'($urandom);
                    step();
                    lat++;
                end
                sc_en = 1'b1;
            end
        end
        sc_en      = hold;
        sc_data_in = NC'($urandom);
        n = 0;
        while (sc_done !== 1'b1 && n < 4) begin
            step();
            lat++;
            n++;
        end
        chk({tag, " done"}, 32'(sc_done), 32'd1);
        chk({tag, " cfg pre-commit"}, 32'(cfg_out), 32'(mshadow));
        step();
        chk({tag, " done 1 cycle"}, 32'(sc_done), 32'd0);
        chk({tag, " idle"}, 32'(sc_busy), 32'd0);
        if (hold) begin
            step();
            chk({tag, " no restart"}, 32'(sc_busy), 32'd0);
        end
        sc_en = 1'b0;
    endtask

    localparam logic [LEN-1:0] A = 10'b1011011011;
    localparam logic [LEN-1:0] B = 10'b0100100100;

    vec_t         tbl[6];
    int           lat;
    logic [W-1:0] rb;
    logic         m;
    logic [W-1:0] d;
    int           pat;
    int           plen;
    logic         hold;
    int           elat;

    initial begin
        tbl[0] = '{1'b0, {B, A}, -1, 0, 1'b0, 10,
                   {B, A}, 1'b1, '0};
        tbl[1] = '{1'b1, '0, -1, 0, 1'b0, 11,
                   {B, A}, 1'b1, {B, A}};
        tbl[2] = '{1'b0, 20'h5a3c6, -1, 0, 1'b1, 10,
                   20'h5a3c6, 1'b1, '0};
        tbl[3] = '{1'b0, {B, A}, 3, 3, 1'b0, 13,
                   {B, A}, 1'b1, '0};
        tbl[4] = '{1'b1, 20'hfffff, 6, 2, 1'b1, 13,
                   {B, A}, 1'b1, {B, A}};
        tbl[5] = '{1'b1, '0, -1, 0, 1'b0, 11,
                   {B, A}, 1'b1, {B, A}};

        clear      = 1'b1;
        sc_en      = 1'b0;
        sc_mode    = 1'b0;
        sc_data_in = '0;
        mshadow    = '0;
        mvalid     = 1'b0;
        step();
        step();
        chk("rst busy", 32'(sc_busy), 32'd0);
        chk("rst done", 32'(sc_done), 32'd0);
        chk("rst cfg", 32'(cfg_out), 32'd0);
        chk("rst valid", 32'(cfg_valid), 32'd0);
        chk("rst dout", 32'(sc_data_out), 32'd0);

        // not armed out of clear even with sc_en high
        clear = 1'b0;
        sc_en = 1'b1;
        step();
        step();
        chk("rst no start", 32'(sc_busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            xfer(t, tbl[i].m, tbl[i].d, tbl[i].pat,
                 tbl[i].plen, tbl[i].hold, lat, rb);
            if (tbl[i].m == 1'b0) begin
                mshadow = tbl[i].d;
                mvalid  = 1'b1;
            end
            chk({t, " lat"}, 32'(lat), 32'(tbl[i].exp_lat));
            chk({t, " cfg"}, 32'(cfg_out), 32'(tbl[i].exp_cfg));
            chk({t, " valid"}, 32'(cfg_valid),
                32'(tbl[i].exp_valid));
            if (tbl[i].m) begin
                chk({t, " rb"}, 32'(rb), 32'(tbl[i].exp_rb));
            end
        end

        // clear after shift 6 of a load, sc_en held high
        sc_en = 1'b0;
        step();
        sc_mode = 1'b0;
        sc_en   = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            sc_data_in = NC'($urandom);
            step();
        end
        clear = 1'b1;
        step();
        clear   = 1'b0;
        mshadow = '0;
        mvalid  = 1'b0;
        chk("clr busy", 32'(sc_busy), 32'd0);
        chk("clr cfg", 32'(cfg_out), 32'd0);
        chk("clr valid", 32'(cfg_valid), 32'd0);
        chk("clr dout", 32'(sc_data_out), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("clr no restart", 32'(sc_busy), 32'd0);
        end
        sc_en = 1'b0;
        step();
        sc_en = 1'b1;
        step();
        chk("clr rearm", 32'(sc_busy), 32'd1);

        // partial load of 5 shifts, clear, then full all-ones
        for (int k = 0; k < 5; k++) begin
            sc_data_in = 2'b10;
            step();
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        xfer("ones", 1'b0, '1, -1, 0, 1'b0, lat, rb);
        mshadow = '1;
        mvalid  = 1'b1;
        chk("ones lat", 32'(lat), 32'(LEN));
        chk("ones cfg", 32'(cfg_out), 32'(20'hfffff));
        chk("ones valid", 32'(cfg_valid), 32'd1);

        // random transfers against the shadow model
        for (int i = 0; i < 24; i++) begin
            string t;
            t    = $sformatf("rnd%0d", i);
            m    = 1'($urandom_range(0, 1));
            d    = W'($urandom);
            hold = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                pat  = $urandom_range(0, LEN - 2);
                plen = $urandom_range(1, 3);
            end else begin
                pat  = -1;
                plen = 0;
            end
            elat = LEN + plen + (m ? 1 : 0);
            xfer(t, m, d, pat, plen, hold, lat, rb);
            chk({t, " lat"}, 32'(lat), 32'(elat));
            if (m) begin
                chk({t, " rb"}, 32'(rb), 32'(mshadow));
            end else begin
                mshadow = d;
                mvalid  = 1'b1;
            end
            chk({t, " cfg"}, 32'(cfg_out), 32'(mshadow));
            chk({t, " valid"}, 32'(cfg_valid), 32'(mvalid));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
